// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers with a stalling data-memory handshake.
// A pending memory access freezes EX/MEM and pushes bubbles into MEM/WB.
`timescale 1ns/1ps
module ex_mem_wb_pipe (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ex_valid_i,
    input  logic        ex_RegWrite_i,
    input  logic        ex_MemtoReg_i,
    input  logic        ex_MemRead_i,
    input  logic        ex_MemWrite_i,
    input  logic [31:0] ex_ALUresult_i,
    input  logic [31:0] ex_RS2data_i,
    input  logic [4:0]  ex_RDaddr_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic        EX_MEM_RegWrite_o,
    output logic [4:0]  EX_MEM_RDaddr_o,
    output logic [31:0] EX_MEM_ALUresult_o,
    output logic        MEM_WB_RegWrite_o,
    output logic [4:0]  MEM_WB_RDaddr_o,
    output logic [31:0] MEM_WB_data_o,
    output logic [15:0] stall_cnt_o
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_em_valid;
    logic        r_em_regwrite;
    logic        r_em_memtoreg;
    logic        r_em_memread;
    logic        r_em_memwrite;
    logic [31:0] r_em_alu;
    logic [31:0] r_em_rs2;
    logic [4:0]  r_em_rd;

    logic        r_wb_valid;
    logic        r_wb_regwrite;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;

    logic [15:0] r_stall_cnt;

    logic        w_mem_req;
    logic        w_stall;
    logic        w_load_sel;

    always_comb begin
        w_mem_req   = r_em_valid & (r_em_memread | r_em_memwrite);
        w_stall     = w_mem_req & ~mem_ack_i;
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_stall) w_state_nxt = S_WAIT;
            S_WAIT:  if (mem_ack_i || !w_mem_req) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Load data is only trusted when a real load request is being acknowledged.
    assign w_load_sel = w_mem_req & r_em_memread & r_em_memtoreg;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_em_valid    <= 1'b0;
            r_em_regwrite <= 1'b0;
            r_em_memtoreg <= 1'b0;
            r_em_memread  <= 1'b0;
            r_em_memwrite <= 1'b0;
            r_em_alu      <= '0;
            r_em_rs2      <= '0;
            r_em_rd       <= '0;
            r_wb_valid    <= 1'b0;
            r_wb_regwrite <= 1'b0;
            r_wb_rd       <= '0;
            r_wb_data     <= '0;
            r_stall_cnt   <= '0;
        end else begin
            if (w_stall) begin
                r_wb_valid <= 1'b0;
            end else begin
                r_em_valid    <= ex_valid_i;
                r_em_regwrite <= ex_RegWrite_i;
                r_em_memtoreg <= ex_MemtoReg_i;
                r_em_memread  <= ex_MemRead_i;
                r_em_memwrite <= ex_MemWrite_i;
                r_em_alu      <= ex_ALUresult_i;
                r_em_rs2      <= ex_RS2data_i;
                r_em_rd       <= ex_RDaddr_i;
                r_wb_valid    <= r_em_valid;
                r_wb_regwrite <= r_em_regwrite;
                r_wb_rd       <= r_em_rd;
                r_wb_data     <= w_load_sel ? mem_rdata_i : r_em_alu;
            end
            if (w_stall && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign mem_req_o          = w_mem_req;
    assign mem_we_o           = r_em_memwrite;
    assign mem_addr_o         = r_em_alu;
    assign mem_wdata_o        = r_em_rs2;
    assign stall_o            = w_stall;
    assign EX_MEM_RegWrite_o  = r_em_valid & r_em_regwrite;
    assign EX_MEM_RDaddr_o    = r_em_rd;
    assign EX_MEM_ALUresult_o = r_em_alu;
    assign MEM_WB_RegWrite_o  = r_wb_valid & r_wb_regwrite;
    assign MEM_WB_RDaddr_o    = r_wb_rd;
    assign MEM_WB_data_o      = r_wb_data;
    assign stall_cnt_o        = r_stall_cnt;
endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Scoreboard bench for ex_mem_wb_pipe: a program-order memory model predicts
// every memory request and write-back; a separate monitor compares them.
`timescale 1ns/1ps
module tb_ex_mem_wb_pipe;
    logic        clk = 1'b0;
    logic        rst_i;
    logic        ex_valid_i, ex_RegWrite_i, ex_MemtoReg_i, ex_MemRead_i, ex_MemWrite_i;
    logic [31:0] ex_ALUresult_i, ex_RS2data_i;
    logic [4:0]  ex_RDaddr_i;
    logic        mem_req_o, mem_we_o, mem_ack_i, stall_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        EX_MEM_RegWrite_o, MEM_WB_RegWrite_o;
    logic [4:0]  EX_MEM_RDaddr_o, MEM_WB_RDaddr_o;
    logic [31:0] EX_MEM_ALUresult_o, MEM_WB_data_o;
    logic [15:0] stall_cnt_o;

    ex_mem_wb_pipe dut (
        .clk_i(clk), .rst_i(rst_i),
        .ex_valid_i(ex_valid_i), .ex_RegWrite_i(ex_RegWrite_i), .ex_MemtoReg_i(ex_MemtoReg_i),
        .ex_MemRead_i(ex_MemRead_i), .ex_MemWrite_i(ex_MemWrite_i),
        .ex_ALUresult_i(ex_ALUresult_i), .ex_RS2data_i(ex_RS2data_i), .ex_RDaddr_i(ex_RDaddr_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .stall_o(stall_o),
        .EX_MEM_RegWrite_o(EX_MEM_RegWrite_o), .EX_MEM_RDaddr_o(EX_MEM_RDaddr_o),
        .EX_MEM_ALUresult_o(EX_MEM_ALUresult_o),
        .MEM_WB_RegWrite_o(MEM_WB_RegWrite_o), .MEM_WB_RDaddr_o(MEM_WB_RDaddr_o),
        .MEM_WB_data_o(MEM_WB_data_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v, rw, m2r, mr, mw;
        logic [31:0] alu, rs2;
        logic [4:0]  rd;
        int          waits;
    } instr_t;
    typedef struct { logic [4:0] rd; logic [31:0] data; int due; } wb_t;
    typedef struct { logic we; logic [31:0] addr, wdata; } mreq_t;

    wb_t         wb_q[$];
    mreq_t       memq[$];
    int          wait_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] env_mem [logic [31:0]];
    int          exp_stalls = 0;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a ^ 32'h5EED_F00D;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic instr_t mk(input logic v, rw, m2r, mr, mw, input logic [31:0] alu, rs2,
                                  input logic [4:0] rd, input int waits);
        instr_t in;
        in.v = v; in.rw = rw; in.m2r = m2r; in.mr = mr; in.mw = mw;
        in.alu = alu; in.rs2 = rs2; in.rd = rd; in.waits = waits;
        return in;
    endfunction

    function automatic instr_t rand_instr();
        instr_t in;
        int k = $urandom_range(0, 9);
        in = mk(1'b1, 1'($urandom), 1'($urandom), 1'b0, 1'b0, $urandom, $urandom, 5'($urandom), 0);
        if (k < 3) begin
            in.mr  = 1'b1;
            in.m2r = ($urandom_range(0, 3) != 0);
            in.alu = 32'($urandom_range(0, 15)) << 2;
        end else if (k < 5) begin
            in.mw  = 1'b1;
            in.alu = 32'($urandom_range(0, 15)) << 2;
        end else if (k == 5) begin
            in.v  = 1'b0;
            in.mr = 1'($urandom);
            in.mw = 1'($urandom);
        end
        if (in.v && (in.mr || in.mw))
            in.waits = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 4);
        return in;
    endfunction

    task automatic drive(input instr_t in);
        ex_valid_i = in.v; ex_RegWrite_i = in.rw; ex_MemtoReg_i = in.m2r;
        ex_MemRead_i = in.mr; ex_MemWrite_i = in.mw;
        ex_ALUresult_i = in.alu; ex_RS2data_i = in.rs2; ex_RDaddr_i = in.rd;
    endtask

    task automatic drive_junk();
        ex_valid_i = 1'($urandom); ex_RegWrite_i = 1'($urandom); ex_MemtoReg_i = 1'($urandom);
        ex_MemRead_i = 1'($urandom); ex_MemWrite_i = 1'($urandom);
        ex_ALUresult_i = $urandom; ex_RS2data_i = $urandom; ex_RDaddr_i = 5'($urandom);
    endtask

    // Called at posedge+2; returns at posedge+2 of the cycle after capture.
    task automatic issue(input instr_t in);
        int          g = 0;
        int          w = 0;
        logic [31:0] d;
        forever begin
            if (stall_o) drive_junk();
            else         drive(in);
            @(negedge clk);
            if (!stall_o) break;
            g++;
            if (g > 90000) begin
                $display("FAIL issue_timeout: stalled %0d cycles, required release", g);
                $fatal(1);
            end
            @(posedge clk); #2;
        end
        if (in.v && (in.mr || in.mw)) begin
            w = in.waits;
            wait_q.push_back(w);
            memq.push_back(mreq_t'{in.mw, in.alu, in.rs2});
            exp_stalls += w;
        end
        if (in.v && in.rw) begin
            if (in.mr && !in.mw && in.m2r)
                d = ref_mem.exists(in.alu) ? ref_mem[in.alu] : init_val(in.alu);
            else
                d = in.alu;
            wb_q.push_back(wb_t'{in.rd, d, cyc + 2 + w});
        end
        if (in.v && in.mw && !in.mr) ref_mem[in.alu] = in.rs2;
        @(posedge clk); #2;
    endtask

    task automatic bubbles(input int n);
        repeat (n) issue(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 0));
    endtask

    // Memory responder: holds each request for the wait count chosen at issue.
    initial begin
        logic busy = 1'b0;
        int   wait_left = 0;
        mem_ack_i = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_req_o) begin
                if (!busy) begin
                    busy = 1'b1;
                    wait_left = (wait_q.size() != 0) ? wait_q.pop_front() : 0;
                end
                if (wait_left == 0) begin
                    mem_ack_i = 1'b1;
                    if (mem_we_o) begin
                        mem_rdata_i = $urandom;
                        env_mem[mem_addr_o] = mem_wdata_o;
                    end else begin
                        mem_rdata_i = env_mem.exists(mem_addr_o) ? env_mem[mem_addr_o] : init_val(mem_addr_o);
                    end
                    busy = 1'b0;
                end else begin
                    mem_ack_i = 1'b0;
                    mem_rdata_i = $urandom;
                    wait_left--;
                end
            end else begin
                busy = 1'b0;
                mem_ack_i = 1'($urandom);
                mem_rdata_i = $urandom;
            end
        end
    end

    // Monitor: compares memory requests and write-backs against the queues.
    initial begin
        wb_t e;
        forever begin
            @(negedge clk);
            chk("stall_rule", 32'(stall_o), 32'(mem_req_o & ~mem_ack_i));
            if (mem_req_o) begin
                if (memq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mem_unexpected: request addr %h, required no request", mem_addr_o);
                end else begin
                    chk("mem_we", 32'(mem_we_o), 32'(memq[0].we));
                    chk("mem_addr", mem_addr_o, memq[0].addr);
                    if (memq[0].we) chk("mem_wdata", mem_wdata_o, memq[0].wdata);
                    if (mem_ack_i) void'(memq.pop_front());
                end
            end
            if (MEM_WB_RegWrite_o) begin
                if (wb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wb_unexpected: rd %0d data %h, required no write-back", MEM_WB_RDaddr_o, MEM_WB_data_o);
                end else begin
                    e = wb_q.pop_front();
                    chk("wb_rd", 32'(MEM_WB_RDaddr_o), 32'(e.rd));
                    chk("wb_data", MEM_WB_data_o, e.data);
                    chk("wb_cycle", cyc, e.due);
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic logic [31:0] sat(input int n);
        return (n > 65535) ? 32'hFFFF : 32'(n);
    endfunction

    initial begin
        rst_i = 1'b0;
        drive(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 0));
        env_mem[32'h40] = 32'hDEADBEEF;
        ref_mem[32'h40] = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_ctrl", 32'({mem_req_o, mem_we_o, stall_o, EX_MEM_RegWrite_o, MEM_WB_RegWrite_o}), 32'd0);
        chk("rst_em_rd", 32'(EX_MEM_RDaddr_o), 32'd0);
        chk("rst_em_alu", EX_MEM_ALUresult_o, 32'd0);
        chk("rst_wb_rd", 32'(MEM_WB_RDaddr_o), 32'd0);
        chk("rst_wb_data", MEM_WB_data_o, 32'd0);
        chk("rst_wdata", mem_wdata_o, 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt_o), 32'd0);
        rst_i = 1'b1;

        issue(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5, 0));
        chk("alu_em_rw", 32'(EX_MEM_RegWrite_o), 32'd1);
        chk("alu_em_rd", 32'(EX_MEM_RDaddr_o), 32'd5);
        chk("alu_em_alu", EX_MEM_ALUresult_o, 32'h1234);
        bubbles(1);
        chk("alu_wb_rw", 32'(MEM_WB_RegWrite_o), 32'd1);
        chk("alu_wb_rd", 32'(MEM_WB_RDaddr_o), 32'd5);
        chk("alu_wb_data", MEM_WB_data_o, 32'h1234);

        issue(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h33, 32'h0, 5'd3, 0));
        issue(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h44, 32'h0, 5'd4, 0));
        chk("b2b_em_rd", 32'(EX_MEM_RDaddr_o), 32'd4);
        chk("b2b_wb_rd", 32'(MEM_WB_RDaddr_o), 32'd3);
        bubbles(2);

        issue(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd7, 3));
        for (int i = 0; i < 3; i++) begin
            drive_junk();
            chk("load_stall", 32'(stall_o), 32'd1);
            chk("load_hold_rd", 32'(EX_MEM_RDaddr_o), 32'd7);
            chk("load_hold_addr", mem_addr_o, 32'h40);
            chk("load_wb_bubble", 32'(MEM_WB_RegWrite_o), 32'd0);
            @(posedge clk); #2;
        end
        bubbles(1);
        chk("load_wb_data", MEM_WB_data_o, 32'hDEADBEEF);
        chk("load_wb_rd", 32'(MEM_WB_RDaddr_o), 32'd7);
        chk("load_stall_cnt", 32'(stall_cnt_o), 32'd3);

        issue(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 32'hA5A5A5A5, 5'd9, 0));
        chk("store_req", 32'(mem_req_o), 32'd1);
        chk("store_we", 32'(mem_we_o), 32'd1);
        chk("store_wdata", mem_wdata_o, 32'hA5A5A5A5);
        chk("store_no_stall", 32'(stall_o), 32'd0);
        bubbles(1);
        chk("store_wb_rw", 32'(MEM_WB_RegWrite_o), 32'd0);

        repeat (400) issue(rand_instr());
        bubbles(4);
        chk("rand_stall_cnt", 32'(stall_cnt_o), sat(exp_stalls));
        chk("rand_wb_drained", wb_q.size(), 32'd0);
        chk("rand_mem_drained", memq.size(), 32'd0);

        issue(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 5'd1, 70000));
        bubbles(3);
        chk("sat_stall_cnt", 32'(stall_cnt_o), sat(exp_stalls));
        chk("sat_value", 32'(stall_cnt_o), 32'hFFFF);

        issue(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 5'd2, 10));
        @(posedge clk); #2;
        @(posedge clk); #2;
        chk("wait_pre_rst_stall", 32'(stall_o), 32'd1);
        rst_i = 1'b0;
        drive(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 0));
        @(posedge clk); #2;
        chk("wrst_req", 32'(mem_req_o), 32'd0);
        chk("wrst_stall", 32'(stall_o), 32'd0);
        chk("wrst_stall_cnt", 32'(stall_cnt_o), 32'd0);
        chk("wrst_rw", 32'({EX_MEM_RegWrite_o, MEM_WB_RegWrite_o}), 32'd0);
        rst_i = 1'b1;
        wb_q.delete();
        memq.delete();
        wait_q.delete();
        exp_stalls = 0;

        issue(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hCAFE0001, 32'h0, 5'd12, 0));
        issue(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 5'd13, 1));
        bubbles(4);
        chk("post_rst_stall_cnt", 32'(stall_cnt_o), sat(exp_stalls));
        chk("post_rst_wb_drained", wb_q.size(), 32'd0);
        chk("post_rst_mem_drained", memq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ex_mem_wb_pipe.md
EX_MEM_WB_PIPE -- requirements
Module: ex_mem_wb_pipe

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk_i and rst_i, listed first.
REQ-002 The ports SHALL be (name  direction  width  meaning):
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active low
- ex_valid_i  in  1  EX stage holds a real instruction
- ex_RegWrite_i  in  1  instruction writes rd
- ex_MemtoReg_i  in  1  write-back selects load data
- ex_MemRead_i  in  1  load
- ex_MemWrite_i  in  1  store
- ex_ALUresult_i  in  32  ALU result / memory address
- ex_RS2data_i  in  32  store data
- ex_RDaddr_i  in  5  destination register
- mem_req_o  out  1  data-memory request
- mem_we_o  out  1  request is a write
- mem_addr_o  out  32  request address
- mem_wdata_o  out  32  store data
- mem_ack_i  in  1  memory completes request this cycle
- mem_rdata_i  in  32  load data, valid when mem_ack_i=1
- stall_o  out  1  upstream SHALL hold EX contents
- EX_MEM_RegWrite_o  out  1  to forwarding unit
- EX_MEM_RDaddr_o  out  5  to forwarding unit
- EX_MEM_ALUresult_o  out  32  forwarded operand
- MEM_WB_RegWrite_o  out  1  to forwarding unit and register file
- MEM_WB_RDaddr_o  out  5  to forwarding unit and register file
- MEM_WB_data_o  out  32  write-back value
- stall_cnt_o  out  16  total memory-wait cycles

Function
REQ-003 The block SHALL contain two registered stages, EX/MEM and MEM/WB, each with a valid bit.
REQ-004 EX_MEM_RegWrite_o SHALL equal EX/MEM valid AND RegWrite; MEM_WB_RegWrite_o SHALL equal MEM/WB valid AND RegWrite.
- RDaddr SHALL pass unmodified, including x0.
REQ-005 mem_req_o SHALL be 1 while EX/MEM is valid with MemRead or MemWrite set, and 0 otherwise.
- mem_we_o = MemWrite.
- mem_addr_o = EX/MEM ALUresult.
- mem_wdata_o = EX/MEM RS2data.
REQ-006 The block SHALL use a two-state FSM, IDLE and WAIT.
- IDLE -> WAIT when mem_req_o=1 and mem_ack_i=0.
- WAIT -> IDLE on mem_ack_i=1.
- IDLE -> IDLE when ack arrives in the request cycle (zero-wait access).
REQ-007 stall_o SHALL be combinational: mem_req_o AND NOT mem_ack_i.
REQ-008 While stall_o=1, the EX/MEM stage SHALL hold all its contents.
- MEM/WB valid SHALL be cleared, inserting a bubble.
- EX inputs SHALL be ignored.
REQ-009 While stall_o=0, EX/MEM SHALL capture the ex_* inputs each cycle.
- MEM/WB SHALL capture EX/MEM contents; its valid = EX/MEM valid.
REQ-010 On the MEM/WB capture edge, the write-back value SHALL be registered:
- mem_rdata_i when MemtoReg=1 and MemRead=1;
- otherwise the ALU result.
REQ-011 Latency SHALL be 2 cycles from EX capture to MEM_WB_* outputs for a non-memory op or a zero-wait access, plus N cycles for N wait cycles.
REQ-012 A store SHALL never assert MEM_WB_RegWrite_o unless ex_RegWrite_i was set. Store data SHALL NOT appear on MEM_WB_data_o.
REQ-013 stall_cnt_o SHALL increment by 1 each cycle stall_o=1 and SHALL saturate at 16'hFFFF with no wrap.
REQ-014 When ex_valid_i=0 is captured, a bubble SHALL result: no request, and RegWrite outputs = 0.
REQ-015 mem_ack_i SHALL be ignored while mem_req_o=0.

Reset
REQ-016 When rst_i=0 at a clock edge, both valid bits SHALL clear, the FSM SHALL enter IDLE, stall_cnt_o SHALL become 0, and all data registers SHALL become 0.
REQ-017 Reset asserted during WAIT SHALL abandon the outstanding request: mem_req_o=0 in the cycle after the reset edge, and no write-back SHALL occur.
REQ-018 With rst_i=1, the first valid EX instruction SHALL be captured on the first clock edge.

Verification
REQ-019 ALU op rd=5, result 0x1234 -> next cycle EX_MEM_RegWrite_o=1, EX_MEM_RDaddr_o=5; following cycle MEM_WB_data_o=0x1234, MEM_WB_RDaddr_o=5.
REQ-020 Load rd=7, addr 0x40, ack delayed 3 cycles, rdata 0xDEADBEEF -> stall_o=1 for 3 cycles, EX/MEM held, MEM_WB_RegWrite_o=0 during stall, then MEM_WB_data_o=0xDEADBEEF, stall_cnt_o=3.
REQ-021 Store addr 0x80, data 0xA5A5A5A5, zero-wait ack -> mem_we_o=1, stall_o never 1, MEM_WB_RegWrite_o=0.
REQ-022 Back-to-back ALU ops rd=3 then rd=4 -> EX_MEM_RDaddr_o=4 while MEM_WB_RDaddr_o=3 in the same cycle.
REQ-023 rst_i=0 during WAIT -> next cycle mem_req_o=0, stall_o=0, stall_cnt_o=0, all RegWrite outputs 0.
REQ-024 Stall forced for 70000 cycles -> stall_cnt_o stays at 0xFFFF.
